// File: rtl/serial_word_assembler_if.sv
// Handshake bundle between a bit-serial producer, the word assembler and the
// parallel word consumer. The slave modport is the assembler's view.
// ONES_COUNT_EN adds the ones_count population-count output.
interface serial_word_assembler_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
);
   logic             start;
   logic             dir;
   logic             bit_in;
   logic             bit_valid;
   logic             bit_ready;
   logic             flush;
   logic [WIDTH-1:0] word_out;
   logic [CNT_W-1:0] word_bits;
   logic             word_valid;
   logic             word_ready;
   logic             busy;
`ifdef ONES_COUNT_EN
   logic [CNT_W-1:0] ones_count;

   modport slave (
      input  start, dir, bit_in, bit_valid, flush, word_ready,
      output bit_ready, word_out, word_bits, word_valid, busy, ones_count
   );
   modport master (
      output start, dir, bit_in, bit_valid, flush, word_ready,
      input  bit_ready, word_out, word_bits, word_valid, busy, ones_count
   );
`else
   modport slave (
      input  start, dir, bit_in, bit_valid, flush, word_ready,
      output bit_ready, word_out, word_bits, word_valid, busy
   );
   modport master (
      output start, dir, bit_in, bit_valid, flush, word_ready,
      input  bit_ready, word_out, word_bits, word_valid, busy
   );
`endif
endinterface

// File: rtl/serial_word_assembler.sv
// Serial-to-parallel word assembler: collects one bit per accepted handshake
// into a WIDTH-bit word (MSB-first or LSB-first) and presents it on a
// valid/ready port. Optional macro ONES_COUNT_EN adds a registered
// population count of the presented word.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  S_IDLE    | no word in progress; waiting for start
//  S_COLLECT | bit_ready high; shifting accepted bits into sr_q
//  S_DONE    | word_valid high; word held until word_ready
module serial_word_assembler #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic                   clock,
   input  logic                   reset_n,
   serial_word_assembler_if.slave sw
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             dir_q, dir_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic [CNT_W-1:0] bits_q, bits_d;

   logic             accept;
   logic [WIDTH-1:0] sr_shift;
   logic [CNT_W-1:0] cnt_inc;
   logic [WIDTH-1:0] sr_now;
   logic [CNT_W-1:0] cnt_now;
   logic             last_bit;

   // Datapath helpers: the shifted register and count if a bit lands now.
   always_comb begin
      accept   = (state_q == S_COLLECT) && sw.bit_valid;
      sr_shift = dir_q ? {sr_q[WIDTH-2:0], sw.bit_in}
                       : {sw.bit_in, sr_q[WIDTH-1:1]};
      cnt_inc  = cnt_q + CNT_W'(1);
      last_bit = accept && (cnt_q == CNT_W'(WIDTH - 1));
      sr_now   = accept ? sr_shift : sr_q;
      cnt_now  = accept ? cnt_inc : cnt_q;
   end

   // Next-state and register-update logic for the collection FSM.
   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      bits_d  = bits_q;
      case (state_q)
         S_IDLE: begin
            if (sw.start) begin
               state_d = S_COLLECT;
               dir_d   = sw.dir;
               sr_d    = '0;
               cnt_d   = '0;
            end
         end
         S_COLLECT: begin
            sr_d  = sr_now;
            cnt_d = cnt_now;
            if (last_bit) begin
               // A full word wins over a coincident flush.
               state_d = S_DONE;
               word_d  = sr_shift;
               bits_d  = CNT_W'(WIDTH);
            end else if (sw.flush) begin
               if (cnt_now != '0) begin
                  state_d = S_DONE;
                  word_d  = sr_now;
                  bits_d  = cnt_now;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_DONE: begin
            if (sw.word_ready) begin
               if (sw.start) begin
                  // Back-to-back: begin the next word without an idle bubble.
                  state_d = S_COLLECT;
                  dir_d   = sw.dir;
                  sr_d    = '0;
                  cnt_d   = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         dir_q   <= 1'b0;
         sr_q    <= '0;
         cnt_q   <= '0;
         word_q  <= '0;
         bits_q  <= '0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         bits_q  <= bits_d;
      end
   end

   assign sw.bit_ready  = (state_q == S_COLLECT);
   assign sw.word_valid = (state_q == S_DONE);
   assign sw.busy       = (state_q != S_IDLE);
   assign sw.word_out   = word_q;
   assign sw.word_bits  = bits_q;

`ifdef ONES_COUNT_EN
   function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < WIDTH; i++) begin
         n = n + CNT_W'(v[i]);
      end
      return n;
   endfunction

   logic [CNT_W-1:0] ones_q;
   logic             enter_done;

   assign enter_done = (state_q == S_COLLECT) && (state_d == S_DONE);

   // Population count captured alongside the word on entry to DONE.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         ones_q <= '0;
      end else if (enter_done) begin
         ones_q <= popcount(word_d);
      end
   end

   assign sw.ones_count = ones_q;
`endif

endmodule

// File: tb/tb_serial_word_assembler.sv
// Directed bench for serial_word_assembler at WIDTH=8.
module tb_serial_word_assembler;
   localparam int WIDTH = 8;
   localparam int CNT_W = $clog2(WIDTH + 1);

   logic clock;
   logic reset_n;
   int   checks;
   int   errors;

   serial_word_assembler_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) sw_if ();

   serial_word_assembler #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .sw      (sw_if.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      sw_if.bit_in    = b;
      sw_if.bit_valid = 1'b1;
      tick();
      sw_if.bit_valid = 1'b0;
   endtask

   task automatic begin_word(input logic d);
      sw_if.start = 1'b1;
      sw_if.dir   = d;
      tick();
      sw_if.start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic chk_ones(input string tag, input logic [31:0] exp);
`ifdef ONES_COUNT_EN
      chk(tag, 32'(sw_if.ones_count), exp);
`endif
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset_n = 1'b0;
      sw_if.start = 1'b0;
      sw_if.dir = 1'b0;
      sw_if.bit_in = 1'b0;
      sw_if.bit_valid = 1'b0;
      sw_if.flush = 1'b0;
      sw_if.word_ready = 1'b0;
      tick();
      tick();
      chk("rst_word_out", 32'(sw_if.word_out), 32'h0);
      chk("rst_word_bits", 32'(sw_if.word_bits), 32'h0);
      chk("rst_word_valid", 32'(sw_if.word_valid), 32'h0);
      chk("rst_bit_ready", 32'(sw_if.bit_ready), 32'h0);
      chk("rst_busy", 32'(sw_if.busy), 32'h0);
      reset_n = 1'b1;
      tick();

      // IDLE ignores bits and flush
      sw_if.bit_valid = 1'b1;
      sw_if.flush = 1'b1;
      tick();
      sw_if.bit_valid = 1'b0;
      sw_if.flush = 1'b0;
      chk("idle_busy", 32'(sw_if.busy), 32'h0);
      chk("idle_bit_ready", 32'(sw_if.bit_ready), 32'h0);

      // Scenario 1: MSB-first 1,0,1,1,0,0,1,0
      begin_word(1'b1);
      chk("s1_bit_ready", 32'(sw_if.bit_ready), 32'h1);
      chk("s1_busy", 32'(sw_if.busy), 32'h1);
      send_byte(8'b1011_0010);
      chk("s1_word_valid", 32'(sw_if.word_valid), 32'h1);
      chk("s1_word_out", 32'(sw_if.word_out), 32'hB2);
      chk("s1_word_bits", 32'(sw_if.word_bits), 32'd8);
      chk_ones("s1_ones", 32'd4);

      // Scenario 3: stall with bit_valid high
      sw_if.bit_valid = 1'b1;
      sw_if.bit_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("s3_word_valid", 32'(sw_if.word_valid), 32'h1);
         chk("s3_word_out", 32'(sw_if.word_out), 32'hB2);
         chk("s3_bit_ready", 32'(sw_if.bit_ready), 32'h0);
      end
      sw_if.bit_valid = 1'b0;
      sw_if.start = 1'b1;
      tick();
      sw_if.start = 1'b0;
      chk("s3_start_ignored_valid", 32'(sw_if.word_valid), 32'h1);
      sw_if.word_ready = 1'b1;
      tick();
      sw_if.word_ready = 1'b0;
      chk("s3_release_busy", 32'(sw_if.busy), 32'h0);
      chk("s3_release_valid", 32'(sw_if.word_valid), 32'h0);

      // Scenario 2: LSB-first same bits
      begin_word(1'b0);
      send_byte(8'b1011_0010);
      chk("s2_word_valid", 32'(sw_if.word_valid), 32'h1);
      chk("s2_word_out", 32'(sw_if.word_out), 32'h4D);
      chk("s2_word_bits", 32'(sw_if.word_bits), 32'd8);
      chk_ones("s2_ones", 32'd4);
      sw_if.word_ready = 1'b1;
      tick();
      sw_if.word_ready = 1'b0;

      // Scenario 4a: flush after 1,0,1 MSB-first
      begin_word(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      chk("s4a_no_valid_yet", 32'(sw_if.word_valid), 32'h0);
      sw_if.flush = 1'b1;
      tick();
      sw_if.flush = 1'b0;
      chk("s4a_word_valid", 32'(sw_if.word_valid), 32'h1);
      chk("s4a_word_out", 32'(sw_if.word_out), 32'h05);
      chk("s4a_word_bits", 32'(sw_if.word_bits), 32'd3);
      chk_ones("s4a_ones", 32'd2);
      sw_if.word_ready = 1'b1;
      tick();
      sw_if.word_ready = 1'b0;

      // Scenario 4b: flush after 1,0,1 LSB-first
      begin_word(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      sw_if.flush = 1'b1;
      tick();
      sw_if.flush = 1'b0;
      chk("s4b_word_out", 32'(sw_if.word_out), 32'hA0);
      chk("s4b_word_bits", 32'(sw_if.word_bits), 32'd3);
      chk_ones("s4b_ones", 32'd2);
      sw_if.word_ready = 1'b1;
      tick();
      sw_if.word_ready = 1'b0;

      // Flush coincident with the only bit: one-bit word
      begin_word(1'b1);
      sw_if.flush = 1'b1;
      send_bit(1'b1);
      sw_if.flush = 1'b0;
      chk("flush_bit_valid", 32'(sw_if.word_valid), 32'h1);
      chk("flush_bit_out", 32'(sw_if.word_out), 32'h01);
      chk("flush_bit_bits", 32'(sw_if.word_bits), 32'd1);
      sw_if.word_ready = 1'b1;
      tick();
      sw_if.word_ready = 1'b0;

      // Flush coincident with the 8th bit: full word
      begin_word(1'b1);
      for (int i = 0; i < 7; i++) send_bit(1'b0);
      sw_if.flush = 1'b1;
      send_bit(1'b1);
      sw_if.flush = 1'b0;
      chk("flush_last_out", 32'(sw_if.word_out), 32'h01);
      chk("flush_last_bits", 32'(sw_if.word_bits), 32'd8);

      // Scenario 5: back-to-back start on handshake
      sw_if.word_ready = 1'b1;
      sw_if.start = 1'b1;
      sw_if.dir = 1'b1;
      tick();
      sw_if.word_ready = 1'b0;
      sw_if.start = 1'b0;
      chk("s5_bit_ready", 32'(sw_if.bit_ready), 32'h1);
      chk("s5_busy", 32'(sw_if.busy), 32'h1);
      chk("s5_valid_low", 32'(sw_if.word_valid), 32'h0);
      send_byte(8'hFF);
      chk("s5_word_out", 32'(sw_if.word_out), 32'hFF);
      chk("s5_word_bits", 32'(sw_if.word_bits), 32'd8);
      chk_ones("s5_ones", 32'd8);
      sw_if.word_ready = 1'b1;
      tick();
      sw_if.word_ready = 1'b0;

      // Scenario 6a: reset mid-word
      begin_word(1'b1);
      send_byte(8'b1010_0000);
      // only 4 bits intended; restart after the byte completed would be wrong,
      // so run a fresh partial word
      sw_if.word_ready = 1'b1;
      tick();
      sw_if.word_ready = 1'b0;
      begin_word(1'b1);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      reset_n = 1'b0;
      tick();
      chk("s6_rst_word_out", 32'(sw_if.word_out), 32'h0);
      chk("s6_rst_word_bits", 32'(sw_if.word_bits), 32'h0);
      chk("s6_rst_valid", 32'(sw_if.word_valid), 32'h0);
      chk("s6_rst_bit_ready", 32'(sw_if.bit_ready), 32'h0);
      chk("s6_rst_busy", 32'(sw_if.busy), 32'h0);
      chk_ones("s6_rst_ones", 32'd0);
      reset_n = 1'b1;
      tick();

      // Scenario 6b: start then flush with no bits
      begin_word(1'b0);
      sw_if.flush = 1'b1;
      tick();
      sw_if.flush = 1'b0;
      chk("s6b_busy", 32'(sw_if.busy), 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("s6b_no_valid", 32'(sw_if.word_valid), 32'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
